lc_line_responder: RTL and testbench

Lower-cache-side responder for the L1 line-fill interface. It terminates the `lc_*` request/response protocol driven by the L1 instruction cache and the L1 data cache, and arbitrates between the two clients. It services one 512-bit line transaction at a time against an internal line-addressed backing store, with a fixed access latency. It sits below `ozone` in the system/bench hierarchy, with one port pair per L1.

---
 rtl/lc_pkg.sv | 31 +++
 rtl/lc_rr_arbiter.sv | 37 +++
 rtl/lc_line_responder.sv | 186 ++++++++++++++++++
 tb/tb_lc_line_responder.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc_pkg.sv
// Shared types and constants for the lc_* line-fill responder.
package lc_pkg;

  localparam int unsigned LC_LINE_BITS        = 512;
  localparam int unsigned LC_LINE_OFFSET_BITS = 6;
  localparam int unsigned LC_ADDR_BITS        = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } lc_resp_state_t;

  typedef enum logic {
    LC_L1I = 1'b0,
    LC_L1D = 1'b1
  } lc_client_e;

  typedef struct packed {
    lc_client_e                id;
    logic                      we;
    logic [LC_ADDR_BITS-1:0]   addr;
    logic [LC_LINE_BITS-1:0]   value;
  } lc_req_t;

  // Clear the byte-within-line offset of a byte address.
  function automatic logic [LC_ADDR_BITS-1:0] lc_line_align(input logic [LC_ADDR_BITS-1:0] a);
    return {a[LC_ADDR_BITS-1:LC_LINE_OFFSET_BITS], LC_LINE_OFFSET_BITS'(0)};
  endfunction

endpackage

// File: rtl/lc_rr_arbiter.sv
// Two-way round-robin arbiter; after reset L1I wins a tie.
module lc_rr_arbiter
  import lc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant,
  output lc_client_e grant_id
);

  lc_client_e last_id;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_id <= LC_L1D;
    end else if (advance) begin
      last_id <= grant_id;
    end
  end

  always_comb begin
    grant_id = LC_L1I;
    case (req)
      2'b01:   grant_id = LC_L1I;
      2'b10:   grant_id = LC_L1D;
      2'b11:   grant_id = (last_id == LC_L1I) ? LC_L1D : LC_L1I;
      default: grant_id = LC_L1I;
    endcase
    grant = 2'b00;
    if (req != 2'b00) begin
      grant = (grant_id == LC_L1D) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/lc_line_responder.sv
// Lower-cache responder for the L1I/L1D line-fill interface with a fixed-latency line store.
// Optional LC_RESP_STATS_EN adds read/write/stall counters.
module lc_line_responder
  import lc_pkg::*;
#(
  parameter int unsigned MEM_LINES = 1024,
  parameter int unsigned LATENCY   = 4
) (
  input  logic                    clk_in,
  input  logic                    rst_N_in,
  input  logic                    cs_N_in,
  input  logic                    l1i_valid_in,
  input  logic [LC_ADDR_BITS-1:0] l1i_addr_in,
  input  logic [LC_LINE_BITS-1:0] l1i_value_in,
  input  logic                    l1i_we_in,
  input  logic                    l1i_ready_in,
  output logic                    l1i_ready_out,
  output logic                    l1i_valid_out,
  output logic [LC_ADDR_BITS-1:0] l1i_addr_out,
  output logic [LC_LINE_BITS-1:0] l1i_value_out,
  input  logic                    l1d_valid_in,
  input  logic [LC_ADDR_BITS-1:0] l1d_addr_in,
  input  logic [LC_LINE_BITS-1:0] l1d_value_in,
  input  logic                    l1d_we_in,
  input  logic                    l1d_ready_in,
  output logic                    l1d_ready_out,
  output logic                    l1d_valid_out,
  output logic [LC_ADDR_BITS-1:0] l1d_addr_out,
  output logic [LC_LINE_BITS-1:0] l1d_value_out
`ifdef LC_RESP_STATS_EN
  ,
  output logic [31:0]             rd_count_out,
  output logic [31:0]             wr_count_out,
  output logic [31:0]             stall_count_out
`endif
);

  localparam int unsigned IDX_W = (MEM_LINES > 1) ? $clog2(MEM_LINES) : 1;
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  lc_resp_state_t          state, state_n;
  logic [CNT_W-1:0]        cnt, cnt_n;
  lc_req_t                 cur, sel, fin;
  logic [1:0]              arb_req, arb_grant;
  lc_client_e              grant_id;
  logic                    accept, commit_wr, load_rd, resp_hs;
  logic [IDX_W-1:0]        fin_idx;
  logic                    valid_i_q, valid_d_q;
  logic [LC_ADDR_BITS-1:0] resp_addr_q;
  logic [LC_LINE_BITS-1:0] resp_value_q;
  logic [LC_LINE_BITS-1:0] mem [MEM_LINES];
  logic                    unused_offset_bits;

  assign arb_req = (rst_N_in && (state == IDLE) && !cs_N_in) ? {l1d_valid_in, l1i_valid_in} : 2'b00;

  lc_rr_arbiter u_arb (
    .clk      (clk_in),
    .rst_n    (rst_N_in),
    .req      (arb_req),
    .advance  (accept),
    .grant    (arb_grant),
    .grant_id (grant_id)
  );

  assign accept        = |arb_grant;
  assign l1i_ready_out = arb_grant[0];
  assign l1d_ready_out = arb_grant[1];

  // Granted request, and the transaction acted on by the final step (live when LATENCY==1).
  always_comb begin
    sel.id = grant_id;
    if (grant_id == LC_L1D) begin
      sel.we    = l1d_we_in;
      sel.addr  = l1d_addr_in;
      sel.value = l1d_value_in;
    end else begin
      sel.we    = l1i_we_in;
      sel.addr  = l1i_addr_in;
      sel.value = l1i_value_in;
    end
  end

  assign fin                = (state == IDLE) ? sel : cur;
  assign fin_idx            = fin.addr[LC_LINE_OFFSET_BITS +: IDX_W];
  assign unused_offset_bits = ^fin.addr[LC_LINE_OFFSET_BITS-1:0];
  assign resp_hs            = (state == RESP) && ((cur.id == LC_L1D) ? l1d_ready_in : l1i_ready_in);

  always_ff @(posedge clk_in) begin
    if (!rst_N_in) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    commit_wr = 1'b0;
    load_rd   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            commit_wr = fin.we;
            load_rd   = !fin.we;
            state_n   = fin.we ? IDLE : RESP;
          end else begin
            state_n = BUSY;
            cnt_n   = CNT_W'(LATENCY - 1);
          end
        end
      end
      BUSY: begin
        cnt_n = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          commit_wr = fin.we;
          load_rd   = !fin.we;
          state_n   = fin.we ? IDLE : RESP;
        end
      end
      RESP: begin
        if (resp_hs) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_N_in) begin
      cur          <= '0;
      valid_i_q    <= 1'b0;
      valid_d_q    <= 1'b0;
      resp_addr_q  <= '0;
      resp_value_q <= '0;
    end else begin
      if (accept) cur <= sel;
      if (load_rd) begin
        resp_addr_q  <= lc_line_align(fin.addr);
        resp_value_q <= mem[fin_idx];
        valid_i_q    <= (fin.id == LC_L1I);
        valid_d_q    <= (fin.id == LC_L1D);
      end else if (resp_hs) begin
        valid_i_q <= 1'b0;
        valid_d_q <= 1'b0;
      end
    end
  end

  // Store contents deliberately survive reset; a reset cycle never commits.
  always_ff @(posedge clk_in) begin
    if (rst_N_in && commit_wr) begin
      mem[fin_idx] <= fin.value;
    end
  end

  assign l1i_valid_out = valid_i_q;
  assign l1d_valid_out = valid_d_q;
  assign l1i_addr_out  = resp_addr_q;
  assign l1d_addr_out  = resp_addr_q;
  assign l1i_value_out = resp_value_q;
  assign l1d_value_out = resp_value_q;

`ifdef LC_RESP_STATS_EN
  logic [31:0] rd_cnt_q, wr_cnt_q, stall_cnt_q;

  always_ff @(posedge clk_in) begin
    if (!rst_N_in) begin
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (accept && !sel.we) rd_cnt_q <= rd_cnt_q + 32'd1;
      if (accept && sel.we)  wr_cnt_q <= wr_cnt_q + 32'd1;
      if ((state == RESP) && !resp_hs) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign rd_count_out    = rd_cnt_q;
  assign wr_count_out    = wr_cnt_q;
  assign stall_count_out = stall_cnt_q;
`endif

endmodule

// File: tb/tb_lc_line_responder.sv
// Scoreboard bench for lc_line_responder at default parameters (MEM_LINES=1024, LATENCY=4).
module tb_lc_line_responder;

  logic         clk_in = 1'b0;
  logic         rst_N_in, cs_N_in;
  logic         l1i_valid_in, l1i_we_in, l1i_ready_in, l1i_ready_out, l1i_valid_out;
  logic         l1d_valid_in, l1d_we_in, l1d_ready_in, l1d_ready_out, l1d_valid_out;
  logic [63:0]  l1i_addr_in, l1i_addr_out, l1d_addr_in, l1d_addr_out;
  logic [511:0] l1i_value_in, l1i_value_out, l1d_value_in, l1d_value_out;
`ifdef LC_RESP_STATS_EN
  logic [31:0]  rd_count_out, wr_count_out, stall_count_out;
`endif

  typedef struct {
    logic         id;
    logic [63:0]  addr;
    logic [511:0] value;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  localparam logic [511:0] PA5 = {64{8'hA5}};
  localparam logic [511:0] PP  = {16{32'hC0DE_0040}};
  localparam logic [511:0] PQ  = {8{64'h0123_4567_89AB_CDEF}};
  localparam logic [511:0] OLD = {16{32'h0DD0_0100}};
  localparam logic [511:0] NEW = {16{32'hBEEF_0100}};

  lc_line_responder dut (
    .clk_in        (clk_in),
    .rst_N_in      (rst_N_in),
    .cs_N_in       (cs_N_in),
    .l1i_valid_in  (l1i_valid_in),
    .l1i_addr_in   (l1i_addr_in),
    .l1i_value_in  (l1i_value_in),
    .l1i_we_in     (l1i_we_in),
    .l1i_ready_in  (l1i_ready_in),
    .l1i_ready_out (l1i_ready_out),
    .l1i_valid_out (l1i_valid_out),
    .l1i_addr_out  (l1i_addr_out),
    .l1i_value_out (l1i_value_out),
    .l1d_valid_in  (l1d_valid_in),
    .l1d_addr_in   (l1d_addr_in),
    .l1d_value_in  (l1d_value_in),
    .l1d_we_in     (l1d_we_in),
    .l1d_ready_in  (l1d_ready_in),
    .l1d_ready_out (l1d_ready_out),
    .l1d_valid_out (l1d_valid_out),
    .l1d_addr_out  (l1d_addr_out),
    .l1d_value_out (l1d_value_out)
`ifdef LC_RESP_STATS_EN
    ,
    .rd_count_out    (rd_count_out),
    .wr_count_out    (wr_count_out),
    .stall_count_out (stall_count_out)
`endif
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Present one request and wait (bounded) for its accept; returns at the start of the next cycle.
  task automatic issue(input logic id, input logic we, input logic [63:0] addr,
                       input logic [511:0] val, output int acc);
    bit got;
    got = 0;
    acc = -1;
    if (id) begin
      l1d_valid_in = 1'b1; l1d_we_in = we; l1d_addr_in = addr; l1d_value_in = val;
    end else begin
      l1i_valid_in = 1'b1; l1i_we_in = we; l1i_addr_in = addr; l1i_value_in = val;
    end
    for (int n = 0; n < 30 && !got; n++) begin
      @(negedge clk_in);
      if ((id ? l1d_ready_out : l1i_ready_out) === 1'b1) begin
        got = 1;
        acc = cyc;
      end
      @(posedge clk_in); #1;
    end
    if (id) l1d_valid_in = 1'b0; else l1i_valid_in = 1'b0;
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL accept_timeout client=%0d addr=%h accepted=0 required=1", id, addr);
    end
  endtask

  // Wait (bounded) for a response to client id; other flags any valid_out seen on the other client.
  task automatic collect(input logic id, output logic [63:0] addr, output logic [511:0] val,
                         output int vcyc, output logic other);
    bit got;
    got   = 0;
    other = 1'b0;
    vcyc  = -1;
    addr  = 'x;
    val   = 'x;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk_in);
      other = other | (id ? l1i_valid_out : l1d_valid_out);
      if ((id ? l1d_valid_out : l1i_valid_out) === 1'b1) begin
        got  = 1;
        vcyc = cyc;
        addr = id ? l1d_addr_out : l1i_addr_out;
        val  = id ? l1d_value_out : l1i_value_out;
      end
      @(posedge clk_in); #1;
    end
  endtask

  task automatic do_reset();
    rst_N_in = 1'b0;
    repeat (2) begin @(posedge clk_in); #1; end
    rst_N_in = 1'b1;
  endtask

  task automatic test_reset();
    rst_N_in = 1'b0; cs_N_in = 1'b0;
    l1i_valid_in = 1'b1; l1d_valid_in = 1'b1;
    l1i_we_in = 1'b0; l1d_we_in = 1'b0;
    l1i_addr_in = '0; l1d_addr_in = '0; l1i_value_in = '0; l1d_value_in = '0;
    l1i_ready_in = 1'b1; l1d_ready_in = 1'b1;
    repeat (2) begin @(posedge clk_in); #1; end
    @(negedge clk_in);
    checks++;
    if ({l1i_ready_out, l1d_ready_out} !== 2'b00) begin
      failures++; $display("FAIL reset_ready got=%b required=00", {l1i_ready_out, l1d_ready_out});
    end
    checks++;
    if ({l1i_valid_out, l1d_valid_out} !== 2'b00) begin
      failures++; $display("FAIL reset_valid got=%b required=00", {l1i_valid_out, l1d_valid_out});
    end
    checks++;
    if ({l1i_addr_out, l1d_addr_out} !== 128'd0) begin
      failures++; $display("FAIL reset_addr got=%h/%h required=0", l1i_addr_out, l1d_addr_out);
    end
    checks++;
    if ((l1i_value_out | l1d_value_out) !== 512'd0) begin
      failures++; $display("FAIL reset_value got=%h required=0", l1i_value_out | l1d_value_out);
    end
    @(posedge clk_in); #1;
    l1i_valid_in = 1'b0; l1d_valid_in = 1'b0;
    rst_N_in = 1'b1;
  endtask

  task automatic test_write_read();
    int wacc, racc, vc;
    logic [63:0] a; logic [511:0] v; logic oth;
    exp_t e;
    issue(1'b1, 1'b1, 64'h80, PA5, wacc);
    sb.push_back('{id: 1'b0, addr: 64'h80, value: PA5});
    issue(1'b0, 1'b0, 64'h80, '0, racc);
    checks++;
    if (racc !== wacc + 4) begin
      failures++; $display("FAIL write_turnaround accept_cycle=%0d required=%0d", racc, wacc + 4);
    end
    collect(1'b0, a, v, vc, oth);
    e = sb.pop_front();
    checks++;
    if (vc - racc !== 4) begin
      failures++; $display("FAIL read_latency got=%0d required=4", vc - racc);
    end
    checks++;
    if (a !== e.addr) begin
      failures++; $display("FAIL wr_rd_addr got=%h required=%h", a, e.addr);
    end
    checks++;
    if (v !== e.value) begin
      failures++; $display("FAIL wr_rd_value got=%h required=%h", v, e.value);
    end
    checks++;
    if (oth !== 1'b0) begin
      failures++; $display("FAIL wr_rd_other_valid got=%b required=0", oth);
    end
  endtask

  task automatic test_alias();
    int wacc, racc, vc;
    logic [63:0] a; logic [511:0] v; logic oth;
    exp_t e;
    issue(1'b0, 1'b1, 64'h40, PP, wacc);
    sb.push_back('{id: 1'b1, addr: 64'h0001_0040, value: PP});
    issue(1'b1, 1'b0, 64'h0001_0047, '0, racc);
    collect(1'b1, a, v, vc, oth);
    e = sb.pop_front();
    checks++;
    if (v !== e.value) begin
      failures++; $display("FAIL alias_value got=%h required=%h", v, e.value);
    end
    checks++;
    if (a !== e.addr) begin
      failures++; $display("FAIL alias_addr got=%h required=%h", a, e.addr);
    end
  endtask

  task automatic test_contention();
    int acc, prev, vc;
    logic [63:0] a; logic [511:0] v; logic oth;
    bit got;
    logic exp_id;
    exp_t e;
    prev = 0;
    do_reset();
    l1i_valid_in = 1'b1; l1i_we_in = 1'b0; l1i_addr_in = 64'h80;
    l1d_valid_in = 1'b1; l1d_we_in = 1'b0; l1d_addr_in = 64'h40;
    for (int k = 0; k < 4; k++) begin
      exp_id = (k % 2 == 1);
      got = 0;
      for (int n = 0; n < 20 && !got; n++) begin
        @(negedge clk_in);
        if (l1i_ready_out === 1'b1 || l1d_ready_out === 1'b1) got = 1;
        else begin @(posedge clk_in); #1; end
      end
      acc = cyc;
      checks++;
      if ({l1d_ready_out, l1i_ready_out} !== (exp_id ? 2'b10 : 2'b01)) begin
        failures++;
        $display("FAIL grant_order round=%0d ready_d_i=%b required=%b", k,
                 {l1d_ready_out, l1i_ready_out}, exp_id ? 2'b10 : 2'b01);
      end
      if (k > 0) begin
        checks++;
        if (acc - prev !== 5) begin
          failures++; $display("FAIL read_throughput round=%0d spacing=%0d required=5", k, acc - prev);
        end
      end
      prev = acc;
      sb.push_back('{id: exp_id, addr: exp_id ? 64'h40 : 64'h80, value: exp_id ? PP : PA5});
      @(posedge clk_in); #1;
      collect(exp_id, a, v, vc, oth);
      e = sb.pop_front();
      checks++;
      if ({a, v} !== {e.addr, e.value}) begin
        failures++; $display("FAIL contention_resp round=%0d addr=%h required=%h", k, a, e.addr);
      end
    end
    l1i_valid_in = 1'b0; l1d_valid_in = 1'b0;
  endtask

  task automatic test_backpressure();
    int wacc, racc, icc, vc, bad;
    logic [63:0] a0; logic [511:0] v0; logic oth; bit got;
    logic [63:0] a; logic [511:0] v;
    exp_t e;
    bad = 0;
    issue(1'b0, 1'b1, 64'h300, PQ, wacc);
    l1d_ready_in = 1'b0;
    sb.push_back('{id: 1'b1, addr: 64'h300, value: PQ});
    issue(1'b1, 1'b0, 64'h300, '0, racc);
    l1i_valid_in = 1'b1; l1i_we_in = 1'b0; l1i_addr_in = 64'h300;
    got = 0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk_in);
      if (l1d_valid_out === 1'b1) got = 1;
      else begin @(posedge clk_in); #1; end
    end
    e = sb.pop_front();
    a0 = l1d_addr_out; v0 = l1d_value_out;
    checks++;
    if ({a0, v0} !== {e.addr, e.value}) begin
      failures++; $display("FAIL bp_resp addr=%h required=%h", a0, e.addr);
    end
    for (int j = 0; j < 10; j++) begin
      if (j > 0) begin @(posedge clk_in); #1; @(negedge clk_in); end
      if ({l1d_valid_out, l1d_addr_out, l1d_value_out, l1i_ready_out, l1d_ready_out}
          !== {1'b1, a0, v0, 2'b00}) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++; $display("FAIL bp_stable unstable_cycles=%0d required=0", bad);
    end
    @(posedge clk_in); #1;
    l1d_ready_in = 1'b1;
    @(negedge clk_in);
    checks++;
    if ({l1d_valid_out, l1i_ready_out} !== 2'b10) begin
      failures++; $display("FAIL bp_handshake valid_d,ready_i=%b required=10", {l1d_valid_out, l1i_ready_out});
    end
    @(posedge clk_in); #1;
    @(negedge clk_in);
    icc = cyc;
    checks++;
    if ({l1d_valid_out, l1i_ready_out} !== 2'b01) begin
      failures++; $display("FAIL bp_release valid_d,ready_i=%b required=01", {l1d_valid_out, l1i_ready_out});
    end
    @(posedge clk_in); #1;
    l1i_valid_in = 1'b0;
    sb.push_back('{id: 1'b0, addr: 64'h300, value: PQ});
    collect(1'b0, a, v, vc, oth);
    e = sb.pop_front();
    checks++;
    if ({v, vc - icc} !== {e.value, 32'd4}) begin
      failures++; $display("FAIL bp_next_read latency=%0d required=4 value=%h", vc - icc, v);
    end
`ifdef LC_RESP_STATS_EN
    checks++;
    if (stall_count_out !== 32'd10) begin
      failures++; $display("FAIL stall_count got=%0d required=10", stall_count_out);
    end
`endif
  endtask

  task automatic test_reset_mid();
    int w, r, vc, bad;
    logic [63:0] a; logic [511:0] v; logic oth;
    exp_t e;
    bad = 0;
    issue(1'b0, 1'b1, 64'h100, OLD, w);
    issue(1'b0, 1'b1, 64'h100, NEW, w);
    rst_N_in = 1'b0;
    @(posedge clk_in); #1;
    rst_N_in = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk_in);
      if ({l1i_valid_out, l1d_valid_out} !== 2'b00) bad++;
      @(posedge clk_in); #1;
    end
    checks++;
    if (bad !== 0) begin
      failures++; $display("FAIL reset_mid_no_resp valid_cycles=%0d required=0", bad);
    end
    sb.push_back('{id: 1'b0, addr: 64'h100, value: OLD});
    issue(1'b0, 1'b0, 64'h100, '0, r);
    collect(1'b0, a, v, vc, oth);
    e = sb.pop_front();
    checks++;
    if (v !== e.value) begin
      failures++; $display("FAIL reset_mid_dropped_write got=%h required=%h", v, e.value);
    end
    sb.push_back('{id: 1'b1, addr: 64'h40, value: PP});
    issue(1'b1, 1'b0, 64'h40, '0, r);
    collect(1'b1, a, v, vc, oth);
    e = sb.pop_front();
    checks++;
    if ({a, v} !== {e.addr, e.value}) begin
      failures++; $display("FAIL store_survives_reset got=%h required=%h", v, e.value);
    end
  endtask

  task automatic test_chip_select();
    int acc, vc, bad;
    logic [63:0] a; logic [511:0] v; logic oth;
    exp_t e;
    bad = 0;
    cs_N_in = 1'b1;
    l1i_valid_in = 1'b1; l1i_we_in = 1'b0; l1i_addr_in = 64'h80;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk_in);
      if ({l1i_ready_out, l1i_valid_out, l1d_valid_out} !== 3'b000) bad++;
      @(posedge clk_in); #1;
    end
    checks++;
    if (bad !== 0) begin
      failures++; $display("FAIL cs_blocks bad_cycles=%0d required=0", bad);
    end
    cs_N_in = 1'b0;
    @(negedge clk_in);
    acc = cyc;
    checks++;
    if (l1i_ready_out !== 1'b1) begin
      failures++; $display("FAIL cs_release_accept ready_i=%b required=1", l1i_ready_out);
    end
    @(posedge clk_in); #1;
    l1i_valid_in = 1'b0;
    sb.push_back('{id: 1'b0, addr: 64'h80, value: PA5});
    collect(1'b0, a, v, vc, oth);
    e = sb.pop_front();
    checks++;
    if ({a, v, vc - acc} !== {e.addr, e.value, 32'd4}) begin
      failures++; $display("FAIL cs_resp addr=%h latency=%0d required=%h/4", a, vc - acc, e.addr);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_alias();
    test_contention();
    test_backpressure();
    test_reset_mid();
    test_chip_select();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
